// File: rtl/elevator_shaft_drive_if.sv
`default_nettype none
// ============================================================================
// elevator_shaft_drive_if : controller <-> shaft drive command/status bundle
// Rev 1.0
// ============================================================================
interface elevator_shaft_drive_if #(
  parameter int POS_W   = 8,
  parameter int FLOOR_W = 3
);
  logic [1:0]         engine_up;
  logic [1:0]         engine_down;
  logic [POS_W-1:0]   pos;
  logic [FLOOR_W-1:0] floor_sensor;
  logic               at_floor;
  logic               floor_pulse;
  logic               moving;
  logic               dir_up;
  logic               fast;
  logic               fault;

  modport master (
    output engine_up, engine_down,
    input  pos, floor_sensor, at_floor, floor_pulse, moving, dir_up, fast, fault
  );

  modport slave (
    input  engine_up, engine_down,
    output pos, floor_sensor, at_floor, floor_pulse, moving, dir_up, fast, fault
  );
endinterface
`default_nettype wire

// File: rtl/elevator_shaft_drive.sv
`default_nettype none
// ============================================================================
// elevator_shaft_drive : integrates motor speed codes into a cabin position
// Rev 1.0
// ============================================================================
module elevator_shaft_drive #(
  parameter int FLOORS          = 8,
  parameter int FLOOR_W         = 3,
  parameter int TICKS_PER_FLOOR = 16,
  parameter int POS_W           = 8,
  parameter int RAMP_CYCLES     = 4
) (
  input wire                    clk,
  input wire                    rst,
  elevator_shaft_drive_if.slave drv
);

  localparam int                    c_tpf_log   = $clog2(TICKS_PER_FLOOR);
  localparam int                    c_ramp_w    = $clog2(RAMP_CYCLES + 1);
  localparam logic [POS_W:0]        c_pos_max   = (POS_W+1)'((FLOORS - 1) * TICKS_PER_FLOOR);
  localparam logic [c_ramp_w-1:0]   c_ramp_full = c_ramp_w'(RAMP_CYCLES);

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_SLOW  = 3'd1,
    ST_FAST  = 3'd2,
    ST_DECEL = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  dir_up_q, dir_up_d;
  logic [c_ramp_w-1:0]   ramp_q, ramp_d;
  logic [FLOOR_W-1:0]    floor_prev_q;
  logic                  floor_pulse_q;

  logic                  w_up, w_dn, w_illegal, w_opp;
  logic [1:0]            w_fwd;
  logic [1:0]            w_step;
  logic                  w_step_up;
  logic [POS_W:0]        w_pos_ext, w_step_ext, w_sum;
  logic [FLOOR_W-1:0]    w_floor;

  assign w_up      = (drv.engine_up != 2'b00);
  assign w_dn      = (drv.engine_down != 2'b00);
  assign w_illegal = (w_up & w_dn) | (drv.engine_up == 2'b11) | (drv.engine_down == 2'b11);
  // Commands are interpreted relative to the current direction of travel.
  assign w_fwd     = dir_up_q ? drv.engine_up : drv.engine_down;
  assign w_opp     = dir_up_q ? w_dn : w_up;

  assign w_pos_ext  = {1'b0, pos_q};
  assign w_step_ext = (POS_W+1)'(w_step);
  assign w_sum      = w_pos_ext + w_step_ext;
  assign w_floor    = FLOOR_W'(pos_q >> c_tpf_log);

  always_comb begin
    state_d   = state_q;
    dir_up_d  = dir_up_q;
    ramp_d    = ramp_q;
    pos_d     = pos_q;
    w_step    = 2'd0;
    w_step_up = dir_up_q;

    if ((state_q != ST_FAULT) && w_illegal) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (w_up) begin
            if (w_pos_ext == c_pos_max) begin
              state_d = ST_FAULT;
            end else begin
              state_d   = ST_SLOW;
              dir_up_d  = 1'b1;
              w_step    = 2'd1;
              w_step_up = 1'b1;
              ramp_d    = c_ramp_w'(1);
            end
          end else if (w_dn) begin
            if (pos_q == '0) begin
              state_d = ST_FAULT;
            end else begin
              state_d   = ST_SLOW;
              dir_up_d  = 1'b0;
              w_step    = 2'd1;
              w_step_up = 1'b0;
              ramp_d    = c_ramp_w'(1);
            end
          end
        end
        ST_SLOW: begin
          if (w_opp) begin
            state_d = ST_FAULT;
          end else if (w_fwd == 2'b00) begin
            state_d = ST_STOP;
          end else if ((w_fwd == 2'b10) && (ramp_q == c_ramp_full)) begin
            state_d = ST_FAST;
            w_step  = 2'd2;
          end else begin
            w_step = 2'd1;
            if ((w_fwd == 2'b10) && (ramp_q < c_ramp_full)) begin
              ramp_d = ramp_q + c_ramp_w'(1);
            end
          end
        end
        ST_FAST: begin
          if (w_opp) begin
            state_d = ST_FAULT;
          end else if (w_fwd == 2'b00) begin
            state_d = ST_DECEL;
            w_step  = 2'd1;
          end else if (w_fwd == 2'b01) begin
            state_d = ST_SLOW;
            w_step  = 2'd1;
            ramp_d  = '0;
          end else begin
            w_step = 2'd2;
          end
        end
        ST_DECEL: state_d = ST_STOP;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_FAULT;
      endcase
    end

    // A step past either end of the shaft pins the cabin at the limit and faults.
    if (w_step != 2'd0) begin
      if (w_step_up) begin
        if (w_sum > c_pos_max) begin
          pos_d   = c_pos_max[POS_W-1:0];
          state_d = ST_FAULT;
        end else begin
          pos_d = w_sum[POS_W-1:0];
        end
      end else begin
        if (w_pos_ext < w_step_ext) begin
          pos_d   = '0;
          state_d = ST_FAULT;
        end else begin
          pos_d = pos_q - POS_W'(w_step);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_STOP;
      pos_q         <= '0;
      dir_up_q      <= 1'b0;
      ramp_q        <= '0;
      floor_prev_q  <= '0;
      floor_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      dir_up_q      <= dir_up_d;
      ramp_q        <= ramp_d;
      floor_prev_q  <= w_floor;
      floor_pulse_q <= (w_floor != floor_prev_q);
    end
  end

  assign drv.pos          = pos_q;
  assign drv.floor_sensor = w_floor;
  assign drv.at_floor     = (pos_q[c_tpf_log-1:0] == '0);
  assign drv.floor_pulse  = floor_pulse_q;
  assign drv.moving       = (state_q == ST_SLOW) || (state_q == ST_FAST) || (state_q == ST_DECEL);
  assign drv.dir_up       = dir_up_q;
  assign drv.fast         = (state_q == ST_FAST);
  assign drv.fault        = (state_q == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_elevator_shaft_drive.sv
`default_nettype none
// ============================================================================
// tb_elevator_shaft_drive : directed + random stimulus against a velocity model
// Rev 1.0
// ============================================================================
module tb_elevator_shaft_drive;

  localparam int TPF     = 16;
  localparam int POS_MAX = 112;
  localparam int RAMP    = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  elevator_shaft_drive_if #(.POS_W(8), .FLOOR_W(3)) bus ();

  elevator_shaft_drive #(
    .FLOORS(8), .FLOOR_W(3), .TICKS_PER_FLOOR(TPF), .POS_W(8), .RAMP_CYCLES(RAMP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .drv (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: signed velocity (+-1 slow, +-2 fast, 0 stopped); decel flag marks the one-step coast.
  int m_pos, m_vel, m_ramp, m_prev_floor;
  bit m_decel, m_fault, m_dirup, m_pulse;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_trip();
    m_fault = 1'b1;
    m_vel   = 0;
    m_decel = 1'b0;
  endtask

  task automatic m_move(input int d);
    int t;
    t = m_pos + d;
    if (t > POS_MAX) begin
      m_pos = POS_MAX;
      m_trip();
    end else if (t < 0) begin
      m_pos = 0;
      m_trip();
    end else begin
      m_pos = t;
    end
  endtask

  task automatic model_step(input int cu, input int cd, input bit r);
    int old_floor, code_f, code_o, mag;
    old_floor = m_pos / TPF;
    if (!r) begin
      m_pos = 0; m_vel = 0; m_ramp = 0; m_decel = 0; m_fault = 0;
      m_dirup = 0; m_pulse = 0; m_prev_floor = 0;
      return;
    end
    m_pulse      = (old_floor != m_prev_floor);
    m_prev_floor = old_floor;
    if (m_fault) return;
    if ((cu != 0 && cd != 0) || cu == 3 || cd == 3) begin
      m_trip();
      return;
    end
    if (m_decel) begin
      m_decel = 0;
      m_vel   = 0;
      return;
    end
    if (m_vel == 0) begin
      if (cu != 0 || cd != 0) begin
        m_dirup = (cu != 0);
        m_vel   = m_dirup ? 1 : -1;
        m_ramp  = 1;
        m_move(m_vel);
      end
      return;
    end
    code_f = m_dirup ? cu : cd;
    code_o = m_dirup ? cd : cu;
    mag    = (m_vel < 0) ? -m_vel : m_vel;
    if (code_o != 0) begin
      m_trip();
    end else if (code_f == 0) begin
      if (mag == 1) begin
        m_vel = 0;
      end else begin
        m_decel = 1;
        m_vel   = m_vel / 2;
        m_move(m_vel);
      end
    end else if (mag == 1) begin
      if (code_f == 2 && m_ramp == RAMP) begin
        m_vel = m_vel * 2;
      end else if (code_f == 2 && m_ramp < RAMP) begin
        m_ramp++;
      end
      m_move(m_vel);
    end else begin
      if (code_f == 1) begin
        m_vel  = m_vel / 2;
        m_ramp = 0;
      end
      m_move(m_vel);
    end
  endtask

  task automatic compare_all();
    int mag;
    mag = (m_vel < 0) ? -m_vel : m_vel;
    check_val("pos",          int'(bus.pos),          m_pos);
    check_val("floor_sensor", int'(bus.floor_sensor), m_pos / TPF);
    check_val("at_floor",     int'(bus.at_floor),     int'(m_pos % TPF == 0));
    check_val("floor_pulse",  int'(bus.floor_pulse),  int'(m_pulse));
    check_val("moving",       int'(bus.moving),       int'(!m_fault && m_vel != 0));
    check_val("dir_up",       int'(bus.dir_up),       int'(m_dirup));
    check_val("fast",         int'(bus.fast),         int'(!m_fault && !m_decel && mag == 2));
    check_val("fault",        int'(bus.fault),        int'(m_fault));
  endtask

  task automatic drive(input logic [1:0] cu, input logic [1:0] cd, input logic r);
    bus.engine_up   = cu;
    bus.engine_down = cd;
    rst             = r;
    @(posedge clk);
    model_step(int'(cu), int'(cd), r);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 1'b0);
    drive(2'b00, 2'b00, 1'b0);
    drive(2'b00, 2'b00, 1'b1);
  endtask

  initial begin
    int exp3 [7];
    int pulses;
    int guard;
    logic [1:0] cu, cd;
    logic r;
    exp3 = '{1, 2, 3, 4, 6, 8, 10};
    n_checks = 0;
    n_errors = 0;
    bus.engine_up   = 2'b00;
    bus.engine_down = 2'b00;
    rst             = 1'b0;

    // Reset state
    do_reset();
    check_val("rst_pos", int'(bus.pos), 0);
    check_val("rst_at_floor", int'(bus.at_floor), 1);

    // Slow climb through one floor boundary
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      drive(2'b01, 2'b00, 1'b1);
      check_val("slow_pos", int'(bus.pos), i + 1);
      pulses += int'(bus.floor_pulse);
    end
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 2'b00, 1'b1);
      pulses += int'(bus.floor_pulse);
    end
    check_val("slow_pulses", pulses, 1);
    check_val("slow_hold_pos", int'(bus.pos), 16);
    check_val("slow_floor", int'(bus.floor_sensor), 1);

    // Acceleration ramp then decel
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(2'b10, 2'b00, 1'b1);
      check_val("ramp_pos", int'(bus.pos), exp3[i]);
      check_val("ramp_fast", int'(bus.fast), int'(i >= 4));
    end
    drive(2'b00, 2'b00, 1'b1);
    check_val("decel_pos", int'(bus.pos), 11);
    drive(2'b00, 2'b00, 1'b1);
    check_val("stop_pos", int'(bus.pos), 11);
    check_val("stop_moving", int'(bus.moving), 0);
    check_val("stop_at_floor", int'(bus.at_floor), 0);

    // Illegal command while moving, fault is sticky
    do_reset();
    drive(2'b01, 2'b00, 1'b1);
    drive(2'b01, 2'b00, 1'b1);
    drive(2'b01, 2'b01, 1'b1);
    check_val("illegal_fault", int'(bus.fault), 1);
    check_val("illegal_pos", int'(bus.pos), 2);
    for (int i = 0; i < 20; i++) begin
      drive(2'($urandom), 2'($urandom), 1'b1);
      check_val("fault_hold", int'(bus.fault), 1);
    end
    do_reset();
    check_val("fault_clear", int'(bus.fault), 0);

    // Overtravel at the top from STOP
    guard = 0;
    while (m_pos < 110 && guard < 200) begin
      drive(2'b10, 2'b00, 1'b1);
      guard++;
    end
    drive(2'b00, 2'b00, 1'b1);
    drive(2'b00, 2'b00, 1'b1);
    drive(2'b01, 2'b00, 1'b1);
    drive(2'b00, 2'b00, 1'b1);
    check_val("top_stop_pos", int'(bus.pos), 112);
    drive(2'b01, 2'b00, 1'b1);
    check_val("top_fault", int'(bus.fault), 1);
    check_val("top_fault_pos", int'(bus.pos), 112);

    // Overtravel from an odd position in FAST clamps
    do_reset();
    drive(2'b01, 2'b00, 1'b1);
    drive(2'b00, 2'b00, 1'b1);
    guard = 0;
    while (!m_fault && guard < 200) begin
      drive(2'b10, 2'b00, 1'b1);
      guard++;
    end
    check_val("clamp_pos", int'(bus.pos), 112);
    check_val("clamp_fault", int'(bus.fault), 1);

    // Down at ground
    do_reset();
    drive(2'b00, 2'b01, 1'b1);
    check_val("ground_fault", int'(bus.fault), 1);
    check_val("ground_pos", int'(bus.pos), 0);

    // Reversal without stopping
    do_reset();
    drive(2'b01, 2'b00, 1'b1);
    drive(2'b01, 2'b00, 1'b1);
    drive(2'b00, 2'b01, 1'b1);
    check_val("reversal_fault", int'(bus.fault), 1);

    // Reset mid-FAST
    do_reset();
    guard = 0;
    while (m_pos < 40 && guard < 200) begin
      drive(2'b10, 2'b00, 1'b1);
      guard++;
    end
    check_val("midfast_fast", int'(bus.fast), 1);
    drive(2'b10, 2'b00, 1'b0);
    check_val("midfast_rst_pos", int'(bus.pos), 0);
    check_val("midfast_rst_moving", int'(bus.moving), 0);

    // Random traffic
    do_reset();
    cu = 2'b00;
    cd = 2'b00;
    for (int i = 0; i < 2500; i++) begin
      int k;
      r = 1'b1;
      if ($urandom_range(0, 299) == 0 || (m_fault && $urandom_range(0, 15) == 0)) r = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 39);
        if (k < 10) begin
          cu = 2'b00; cd = 2'b00;
        end else if (k < 24) begin
          cu = 2'($urandom_range(1, 2)); cd = 2'b00;
        end else if (k < 38) begin
          cu = 2'b00; cd = 2'($urandom_range(1, 2));
        end else begin
          cu = 2'($urandom_range(0, 3)); cd = 2'($urandom_range(1, 3));
        end
      end
      drive(cu, cd, r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
